// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default parameters,
// the IF/ID payload record and the next-PC selector.
package if_stage_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam int          DEF_IM_AW    = 10;
  localparam logic [31:0] DEF_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_HOLD     = 2'd0,
    NPC_REDIRECT = 2'd1,
    NPC_SEQ      = 2'd2
  } npc_sel_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [31:0]        pc4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } ifid_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold has priority over flush; flush loads a bubble.
// Asynchronous active-low clear to the same bubble value.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP = DEF_NOP
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  hold,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  localparam ifid_t BUBBLE = '{pc: 32'd0, pc4: 32'd0, instr: NOP, valid: 1'b0};

  ifid_t q_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_reg <= BUBBLE;
    end else if (hold) begin
      q_reg <= q_reg;
    end else if (flush) begin
      q_reg <= BUBBLE;
    end else begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch range check,
// fault/delivery bookkeeping, and the IF/ID register handed to decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          IM_AW    = DEF_IM_AW,
  parameter logic [31:0] NOP      = DEF_NOP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [IM_AW-1:0] imem_index,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic             fetch_fault,
  output logic [31:0]      fetch_count
);

  logic [31:0] pc_reg, pc_next;
  logic        fault_reg, fault_next;
  logic [31:0] count_reg, count_next;
  npc_sel_e    npc_sel;

  logic [31:0] pc4;
  logic [31:0] pc_off;
  logic [31:0] pc_word;
  logic        in_range;
  logic [31:0] fetched;

  ifid_t ifid_d, ifid_q;

  // Word offset from the memory base; the upper bits must be zero to be in range.
  assign pc4        = pc_reg + 32'd4;
  assign pc_off     = pc_reg - RESET_PC;
  assign pc_word    = pc_off >> 2;
  assign in_range   = (pc_reg >= RESET_PC) && ((pc_word >> IM_AW) == 32'd0);
  assign imem_index = pc_word[IM_AW-1:0];
  assign fetched    = in_range ? imem_rdata : NOP;

  always_comb begin
    npc_sel    = NPC_SEQ;
    pc_next    = pc_reg;
    fault_next = fault_reg;
    count_next = count_reg;

    if (stall) begin
      npc_sel = NPC_HOLD;
    end else if (redirect) begin
      npc_sel = NPC_REDIRECT;
    end

    case (npc_sel)
      NPC_HOLD: begin
        pc_next = pc_reg;
      end
      NPC_REDIRECT: begin
        pc_next = word_align(redirect_pc);
        if (redirect_pc[1:0] != 2'b00) begin
          fault_next = 1'b1;
        end
      end
      NPC_SEQ: begin
        pc_next    = pc4;
        count_next = count_reg + {31'd0, in_range};
        if (!in_range) begin
          fault_next = 1'b1;
        end
      end
      default: begin
        pc_next = pc_reg;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg    <= RESET_PC;
      fault_reg <= 1'b0;
      count_reg <= 32'd0;
    end else begin
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
      count_reg <= count_next;
    end
  end

  // An out-of-range fetch travels down as a NOP bubble rather than a real instruction.
  assign ifid_d = '{pc: pc_reg, pc4: pc4, instr: fetched, valid: in_range};

  if_id_reg #(
    .NOP (NOP)
  ) u_if_id_reg (
    .clock (clock),
    .reset (reset),
    .hold  (npc_sel == NPC_HOLD),
    .flush (npc_sel == NPC_REDIRECT),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign pc          = pc_reg;
  assign id_pc       = ifid_q.pc;
  assign id_pc4      = ifid_q.pc4;
  assign id_instr    = ifid_q.instr;
  assign id_valid    = ifid_q.valid;
  assign fetch_fault = fault_reg;
  assign fetch_count = count_reg;

endmodule
